// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC generator with trap/epc handling and a circular return-address stack.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = 'h80,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           br_taken,
  input  logic [WIDTH-1:0]               br_target,
  input  logic                           jmp,
  input  logic [WIDTH-1:0]               jmp_target,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           trap,
  input  logic                           eret,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_4,
  output logic [WIDTH-1:0]               epc,
  output logic [WIDTH-1:0]               ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam logic [WIDTH-1:0] AMASK = ~(WIDTH'(STEP - 1));
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  logic [WIDTH-1:0] pc_nxt;
  logic go, do_eret, do_ret, do_br, do_jmp, push, pop, empty, full;
  assign pc_4     = pc + WIDTH'(STEP);
  assign empty    = ras_count == '0;
  assign full     = ras_count == CW'(RAS_DEPTH);
  assign ras_top  = empty ? '0 : ras[ptr];
  assign ptr_inc  = (ptr == PW'(RAS_DEPTH - 1)) ? '0 : ptr + PW'(1);
  assign ptr_dec  = (ptr == '0) ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);
  // one-hot source selection: trap outranks everything, including a stall
  assign go       = en & ~trap;
  assign do_eret  = go & eret;
  assign do_ret   = go & ~eret & ret;
  assign do_br    = go & ~eret & ~ret & br_taken;
  assign do_jmp   = go & ~eret & ~ret & ~br_taken & jmp;
  assign push     = do_jmp & call;
  assign pop      = do_ret & ~empty;
  assign pc_nxt   = trap    ? TRAP_VEC :
                    do_eret ? epc & AMASK :
                    do_ret  ? (empty ? pc_4 : ras[ptr] & AMASK) :
                    do_br   ? br_target & AMASK :
                    do_jmp  ? jmp_target & AMASK :
                    go      ? pc_4 : pc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VEC;
      epc       <= '0;
      ptr       <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      pc      <= pc_nxt;
      ras_unf <= do_ret & empty;
      if (trap) epc <= pc;
      if (push) begin
        ptr          <= ptr_inc;
        ras[ptr_inc] <= pc_4;
        if (full) ras_ovf <= 1'b1;
        else ras_count <= ras_count + CW'(1);
      end else if (pop) begin
        ptr       <= ptr_dec;
        ras_count <= ras_count - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed-vector bench for pc_gen with default parameters.
module tb_pc_gen;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, br_taken = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0, trap = 1'b0, eret = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] pc, pc_4, epc, ras_top;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf;
  int checks = 0, failures = 0;

  pc_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target), .call(call), .ret(ret), .trap(trap), .eret(eret),
    .pc(pc), .pc_4(pc_4), .epc(epc), .ras_top(ras_top), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; br_taken = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; trap = 1'b0; eret = 1'b0;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle(); en = 1'b1; jmp = 1'b1; call = 1'b1; jmp_target = tgt;
    step();
  endtask

  task automatic do_ret();
    idle(); en = 1'b1; ret = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] a [5];
    // reset state
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cnt", 32'(ras_count), 32'd0);
    chk("rst_top", ras_top, 32'h0);
    chk("rst_ovf", 32'(ras_ovf), 32'd0);
    chk("rst_unf", 32'(ras_unf), 32'd0);
    // 1: sequential stepping then stall
    en = 1'b1;
    #10 rst_n = 1'b1;
    chk("seq_pc0", pc, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", pc, 32'(4 * i));
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h10);
      chk("stall_pc4", pc_4, 32'h14);
    end
    // 2: call and matching return
    do_call(32'h100);
    chk("call_pc", pc, 32'h100);
    chk("call_top", ras_top, 32'h14);
    chk("call_cnt", 32'(ras_count), 32'd1);
    do_ret();
    chk("ret_pc", pc, 32'h14);
    chk("ret_cnt", 32'(ras_count), 32'd0);
    chk("ret_top", ras_top, 32'h0);
    // 3: overflow the stack with 5 nested calls, then drain it and underflow once
    a = '{32'h18, 32'h204, 32'h304, 32'h404, 32'h504};
    for (int i = 0; i < 5; i++) begin
      do_call(32'(32'h200 + 32'h100 * i));
      chk("nest_pc", pc, 32'(32'h200 + 32'h100 * i));
      chk("nest_top", ras_top, a[i]);
      chk("nest_cnt", 32'(ras_count), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("nest_ovf", 32'(ras_ovf), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 4; i >= 1; i--) begin
      do_ret();
      chk("pop_pc", pc, a[i]);
      chk("pop_cnt", 32'(ras_count), 32'(i - 1));
      chk("pop_unf", 32'(ras_unf), 32'd0);
    end
    do_ret();
    chk("unf_pc", pc, 32'h208);
    chk("unf_pulse", 32'(ras_unf), 32'd1);
    chk("unf_cnt", 32'(ras_count), 32'd0);
    chk("unf_ovf_sticky", 32'(ras_ovf), 32'd1);
    idle(); en = 1'b1;
    step();
    chk("unf_clear", 32'(ras_unf), 32'd0);
    chk("unf_next_pc", pc, 32'h20c);
    // 4: trap beats a stalled branch; eret beats ret and leaves the RAS alone
    do_call(32'h40);
    chk("pre_trap_top", ras_top, 32'h210);
    idle(); trap = 1'b1; br_taken = 1'b1; br_target = 32'h300;
    step();
    chk("trap_pc", pc, 32'h80);
    chk("trap_epc", epc, 32'h40);
    chk("trap_cnt", 32'(ras_count), 32'd1);
    idle(); en = 1'b1; eret = 1'b1; ret = 1'b1;
    step();
    chk("eret_pc", pc, 32'h40);
    chk("eret_cnt", 32'(ras_count), 32'd1);
    chk("eret_top", ras_top, 32'h210);
    chk("eret_unf", 32'(ras_unf), 32'd0);
    // 5: wraparound and target alignment
    idle(); en = 1'b1; jmp = 1'b1; jmp_target = 32'hFFFF_FFFE;
    step();
    chk("align_jmp", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_4, 32'h0);
    idle(); en = 1'b1;
    step();
    chk("wrap_pc", pc, 32'h0);
    idle(); en = 1'b1; br_taken = 1'b1; br_target = 32'h103;
    step();
    chk("align_br", pc, 32'h100);
    // 6: asynchronous reset in the middle of a call sequence
    do_call(32'h300);
    chk("pre_rst_cnt", 32'(ras_count), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_cnt", 32'(ras_count), 32'd0);
    chk("arst_ovf", 32'(ras_ovf), 32'd0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_top", ras_top, 32'h0);
    idle(); en = 1'b1;
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_pc", pc, 32'h4);
    step();
    chk("post_rst_pc2", pc, 32'h8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
